// File: rtl/sdram_wb_arbiter.sv
// N-channel Wishbone front end for sdram_controller: round-robin grant, one controller
// request per transaction, single-cycle ack/err, and a read watchdog.
module sdram_wb_arbiter #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [NCH-1:0]      ch_cyc_i,
    input  logic [NCH-1:0]      ch_stb_i,
    input  logic [NCH-1:0]      ch_we_i,
    input  logic [4*NCH-1:0]    ch_sel_i,
    input  logic [32*NCH-1:0]   ch_adr_i,
    input  logic [32*NCH-1:0]   ch_dat_i,
    output logic [NCH-1:0]      ch_ack_o,
    output logic [NCH-1:0]      ch_err_o,
    output logic [31:0]         ch_dat_o,
    output logic [ADDR_W-1:0]   ctrl_addr,
    output logic                ctrl_rw,
    output logic [31:0]         ctrl_wdata,
    output logic [3:0]          ctrl_mask,
    output logic                ctrl_in_valid,
    input  logic                ctrl_busy,
    input  logic                ctrl_out_valid,
    input  logic [31:0]         ctrl_rdata
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StAck} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     grant_q, last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        mask_q;
    logic [TW-1:0]     wd_q;
    logic              err_q;
    logic [31:0]       dat_q;

    logic [NCH-1:0]    req;
    logic              any_req;
    logic [CW-1:0]     pick;
    int unsigned       pick_idx;
    logic              latch, accept, rd_done, rd_timeout;

    // Address bits outside the forwarded word address are intentionally dropped.
    logic unused_adr;
    assign unused_adr = ^ch_adr_i;

    // Round-robin: first requester after the last granted channel.
    always_comb begin
        req      = ch_cyc_i & ch_stb_i;
        any_req  = 1'b0;
        pick_idx = 32'(last_grant_q);
        for (int unsigned k = 1; k <= NCH; k++) begin
            int unsigned idx;
            idx = (32'(last_grant_q) + k) % NCH;
            if (!any_req && req[idx]) begin
                any_req  = 1'b1;
                pick_idx = idx;
            end
        end
        pick = CW'(pick_idx);
    end

    always_comb begin
        state_d    = state_q;
        latch      = 1'b0;
        accept     = 1'b0;
        rd_done    = 1'b0;
        rd_timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    latch   = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!ctrl_busy) begin
                    accept  = 1'b1;
                    state_d = we_q ? StAck : StWaitRd;
                end
            end
            StWaitRd: begin
                if (ctrl_out_valid) begin
                    rd_done = 1'b1;
                    state_d = StAck;
                end else if (wd_q == TW'(TIMEOUT - 1)) begin
                    rd_timeout = 1'b1;
                    state_d    = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= CW'(NCH - 1);
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            wd_q         <= '0;
            err_q        <= 1'b0;
            dat_q        <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                grant_q <= pick;
                we_q    <= ch_we_i[pick];
                addr_q  <= ch_adr_i[32*pick_idx + 2 +: ADDR_W];
                wdata_q <= ch_dat_i[32*pick_idx +: 32];
                mask_q  <= ch_sel_i[4*pick_idx +: 4] & {4{ch_we_i[pick]}};
                err_q   <= 1'b0;
            end
            if (accept) begin
                wd_q <= '0;
            end else if (state_q == StWaitRd) begin
                wd_q <= wd_q + TW'(1);
            end
            if (accept && we_q) begin
                dat_q <= '0;
            end else if (rd_done) begin
                dat_q <= ctrl_rdata;
            end else if (rd_timeout) begin
                dat_q <= '0;
                err_q <= 1'b1;
            end
            if (state_q == StAck) begin
                last_grant_q <= grant_q;
            end
        end
    end

    assign ctrl_in_valid = (state_q == StIssue);
    assign ctrl_addr     = addr_q;
    assign ctrl_rw       = we_q;
    assign ctrl_wdata    = wdata_q;
    assign ctrl_mask     = mask_q;
    assign ch_dat_o      = dat_q;

    // A master that abandoned its cycle gets no response.
    always_comb begin
        ch_ack_o = '0;
        ch_err_o = '0;
        if (state_q == StAck && ch_cyc_i[grant_q]) begin
            if (err_q) begin
                ch_err_o[grant_q] = 1'b1;
            end else begin
                ch_ack_o[grant_q] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Bench for sdram_wb_arbiter: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed latencies, grant order and counts.
module tb_sdram_wb_arbiter;

    localparam int NCH     = 2;
    localparam int ADDR_W  = 23;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NCH-1:0]      cyc_i, stb_i, we_i;
    logic [4*NCH-1:0]    sel_i;
    logic [32*NCH-1:0]   adr_i, dat_i;
    logic [NCH-1:0]      ack_o, err_o;
    logic [31:0]         dat_o;
    logic [ADDR_W-1:0]   c_addr;
    logic                c_rw, c_inv, c_busy, c_ov;
    logic [31:0]         c_wdata, c_rdata;
    logic [3:0]          c_mask;

    sdram_wb_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .ch_cyc_i       (cyc_i),
        .ch_stb_i       (stb_i),
        .ch_we_i        (we_i),
        .ch_sel_i       (sel_i),
        .ch_adr_i       (adr_i),
        .ch_dat_i       (dat_i),
        .ch_ack_o       (ack_o),
        .ch_err_o       (err_o),
        .ch_dat_o       (dat_o),
        .ctrl_addr      (c_addr),
        .ctrl_rw        (c_rw),
        .ctrl_wdata     (c_wdata),
        .ctrl_mask      (c_mask),
        .ctrl_in_valid  (c_inv),
        .ctrl_busy      (c_busy),
        .ctrl_out_valid (c_ov),
        .ctrl_rdata     (c_rdata)
    );

    initial forever #5 clk = ~clk;

    int total = 0, bad = 0;
    int cycle_n = 0;
    int n_inv = 0, n_acc = 0, n_ack = 0, n_err = 0;
    int gq[$];

    always @(posedge clk) cycle_n <= cycle_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cycle_n, act, exp);
        end
    endtask

    // Model: one outstanding transaction record; outputs follow from where it is in its life.
    initial begin : model
        int lg, ch, wait_left;
        bit have, issuing, waiting, ack_now, ack_err;
        logic we;
        logic [ADDR_W-1:0] a;
        logic [31:0] wd, hold;
        logic [3:0] m;
        logic [NCH-1:0] exp_ack, exp_err, r;
        lg = NCH - 1; ch = 0; wait_left = 0;
        have = 0; issuing = 0; waiting = 0; ack_now = 0; ack_err = 0;
        we = 0; a = '0; wd = '0; hold = '0; m = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_ack = '0;
            exp_err = '0;
            if (ack_now && cyc_i[ch]) begin
                if (ack_err) exp_err[ch] = 1'b1;
                else         exp_ack[ch] = 1'b1;
            end
            check("m_in_valid", c_inv, issuing);
            check("m_addr", c_addr, a);
            check("m_rw", c_rw, we);
            check("m_wdata", c_wdata, wd);
            check("m_mask", c_mask, m);
            check("m_ack", ack_o, exp_ack);
            check("m_err", err_o, exp_err);
            check("m_dat", dat_o, hold);
            if (c_inv) n_inv++;
            if (c_inv && !c_busy) n_acc++;
            for (int c = 0; c < NCH; c++) begin
                if (ack_o[c]) begin
                    n_ack++;
                    gq.push_back(c);
                end
                if (err_o[c]) n_err++;
            end
            r = cyc_i & stb_i;
            if (rst) begin
                lg = NCH - 1; have = 0; issuing = 0; waiting = 0; ack_now = 0;
                we = 0; a = '0; wd = '0; m = '0; hold = '0;
            end else if (ack_now) begin
                lg = ch; ack_now = 0; have = 0;
            end else if (!have) begin
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (lg + k) % NCH;
                    if (!have && r[c]) begin
                        have = 1; issuing = 1; ch = c;
                        we = we_i[c];
                        a = adr_i[32*c + 2 +: ADDR_W];
                        wd = dat_i[32*c +: 32];
                        m = sel_i[4*c +: 4] & {4{we_i[c]}};
                    end
                end
            end else if (issuing) begin
                if (!c_busy) begin
                    issuing = 0;
                    if (we) begin
                        ack_now = 1; ack_err = 0; hold = '0;
                    end else begin
                        waiting = 1; wait_left = TIMEOUT;
                    end
                end
            end else if (waiting) begin
                if (c_ov) begin
                    waiting = 0; ack_now = 1; ack_err = 0; hold = c_rdata;
                end else begin
                    wait_left--;
                    if (wait_left == 0) begin
                        waiting = 0; ack_now = 1; ack_err = 1; hold = '0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int c, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
        cyc_i[c] = 1'b1;
        stb_i[c] = 1'b1;
        we_i[c]  = we;
        adr_i[32*c +: 32] = adr;
        dat_i[32*c +: 32] = dat;
        sel_i[4*c +: 4]   = sel;
    endtask

    task automatic drop(input int c);
        cyc_i[c] = 1'b0;
        stb_i[c] = 1'b0;
    endtask

    task automatic wait_resp(input int c, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack_o[c] || err_o[c]) begin
                at = cycle_n;
                break;
            end
        end
        check("resp_seen", at >= 0, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        int t0, at, s_inv, s_acc, s_ack, s_err, base, bq;
        cyc_i = '0; stb_i = '0; we_i = '0; sel_i = '0; adr_i = '0; dat_i = '0;
        c_busy = 1'b0; c_ov = 1'b0; c_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_inv", c_inv, 0);
        check("rst_ack", ack_o, 0);
        check("rst_addr", c_addr, 0);

        // out_valid while idle must not disturb read data
        tick();
        c_ov = 1'b1; c_rdata = 32'h1234_5678;
        tick();
        c_ov = 1'b0; c_rdata = '0;
        @(negedge clk);
        check("idle_ov_dat", dat_o, 0);

        // ch0 write, busy low
        tick();
        s_inv = n_inv;
        req(0, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 4'hF);
        t0 = cycle_n;
        @(negedge clk);
        check("t1_idle_inv", c_inv, 0);
        tick();
        @(negedge clk);
        check("t1_inv", c_inv, 1);
        check("t1_addr", c_addr, 4);
        check("t1_mask", c_mask, 4'hF);
        check("t1_wdata", c_wdata, 32'hA5A5_0001);
        wait_resp(0, 10, at);
        check("t1_lat", at - t0, 2);    // IDLE, ISSUE, ACK
        check("t1_ack", ack_o, 2'b01);
        tick();
        drop(0);
        check("t1_inv_cycles", n_inv - s_inv, 1);

        // ch1 read, data five cycles after issue
        req(1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
        t0 = cycle_n;
        tick();
        @(negedge clk);
        check("t2_mask", c_mask, 0);
        check("t2_addr", c_addr, 8);
        check("t2_rw", c_rw, 0);
        repeat (5) tick();
        c_ov = 1'b1; c_rdata = 32'hDEAD_BEEF;
        tick();
        c_ov = 1'b0; c_rdata = '0;
        @(negedge clk);
        check("t2_lat", cycle_n - t0, 7);
        check("t2_ack", ack_o, 2'b10);
        check("t2_dat", dat_o, 32'hDEAD_BEEF);
        tick();
        drop(1);
        @(negedge clk);
        check("t2_dat_hold", dat_o, 32'hDEAD_BEEF);

        // both channels requesting continuously
        tick();
        base = n_ack;
        bq = gq.size();
        req(0, 1'b1, 32'h0000_0100, 32'h11, 4'h3);
        req(1, 1'b1, 32'h0000_0200, 32'h22, 4'hC);
        for (int i = 0; i < 60 && n_ack - base < 4; i++) tick();
        drop(0);
        drop(1);
        check("t3_count", n_ack - base, 4);
        for (int i = 0; i < 4; i++) begin
            check("t3_grant", (bq + i < gq.size()) ? gq[bq+i] : -1, i % 2);
        end

        // busy held ten cycles during issue
        c_busy = 1'b1;
        s_inv = n_inv; s_acc = n_acc; s_ack = n_ack;
        req(0, 1'b1, 32'h0000_0040, 32'hCAFE_0004, 4'hF);
        t0 = cycle_n;
        repeat (11) tick();
        c_busy = 1'b0;
        wait_resp(0, 10, at);
        check("t4_lat", at - t0, 12);
        tick();
        drop(0);
        check("t4_inv_cycles", n_inv - s_inv, 11);
        check("t4_accepts", n_acc - s_acc, 1);
        check("t4_acks", n_ack - s_ack, 1);

        // read watchdog
        s_ack = n_ack; s_err = n_err;
        req(1, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
        t0 = cycle_n;
        wait_resp(1, 40, at);
        check("t5_lat", at - t0, 2 + TIMEOUT);
        check("t5_err", err_o, 2'b10);
        check("t5_ack", ack_o, 2'b00);
        check("t5_dat", dat_o, 0);
        tick();
        drop(1);
        check("t5_errs", n_err - s_err, 1);
        check("t5_acks", n_ack - s_ack, 0);

        // master abandons its cycle during issue
        c_busy = 1'b1;
        s_ack = n_ack; s_acc = n_acc;
        req(0, 1'b1, 32'h0000_0044, 32'h77, 4'h1);
        tick();
        tick();
        drop(0);
        repeat (2) tick();
        c_busy = 1'b0;
        repeat (5) tick();
        check("t7_acks", n_ack - s_ack, 0);
        check("t7_accepts", n_acc - s_acc, 1);

        // reset while waiting for read data
        req(0, 1'b1, 32'h0000_0048, 32'h88, 4'hF);
        wait_resp(0, 10, at);
        tick();
        drop(0);
        req(1, 1'b0, 32'h0000_0090, 32'h0, 4'hF);
        repeat (3) tick();
        drop(1);
        rst = 1'b1;
        s_ack = n_ack; s_err = n_err; s_inv = n_inv;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        check("t6_acks", n_ack - s_ack, 0);
        check("t6_errs", n_err - s_err, 0);
        check("t6_inv", n_inv - s_inv, 0);
        @(negedge clk);
        check("t6_addr", c_addr, 0);
        tick();
        req(0, 1'b1, 32'h0000_004C, 32'h1, 4'hF);
        req(1, 1'b1, 32'h0000_0094, 32'h2, 4'hF);
        t0 = cycle_n;
        wait_resp(0, 10, at);
        check("t6_first_ch0", at - t0, 2);
        tick();
        drop(0);
        drop(1);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
